irq_ctrl: RTL and testbench

// Machine-mode interrupt/trap source for the core; drives I_interrupt and I_mtvec of pc_sel.

---
 rtl/irq_ctrl_pkg.sv | 37 +++
 rtl/irq_ctrl_sync.sv | 20 ++
 rtl/irq_ctrl.sv | 155 +++++++++++++++
 tb/tb_irq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared CSR addresses, bit positions, cause codes and FSM encodings for the
// machine-mode interrupt controller.
package irq_ctrl_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // Same bit positions are used in both mie and mip.
   localparam int IRQ_MSI = 3;
   localparam int IRQ_MTI = 7;
   localparam int IRQ_MEI = 11;

   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   localparam logic ST_RUN  = 1'b0;
   localparam logic ST_TRAP = 1'b1;

   typedef struct packed {
      logic       irq;
      logic [3:0] code;
   } mcause_t;

   // Fixed priority MEI > MSI > MTI; only meaningful when something is pending.
   function automatic logic [3:0] pickCause(input logic mei, input logic msi);
      return mei ? CAUSE_MEI : (msi ? CAUSE_MSI : CAUSE_MTI);
   endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// Multi-stage flop synchroniser for the asynchronous external interrupt line.
module irq_sync #(
   parameter int STAGES = 2
) (
   input  logic I_clk,
   input  logic I_rst,
   input  logic I_d,
   output logic O_q
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge I_clk) begin
      if (I_rst) chain_q <= '0;
      else       chain_q <= {chain_q[STAGES-2:0], I_d};
   end

   assign O_q = chain_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: CSR file, masking, priority arbitration
// and a one-cycle redirect pulse towards pc_sel, plus mret restore.
module irq_ctrl #(
   parameter logic [31:0] RESET_MTVEC = 32'h00000010,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_ext_irq,
   input  logic        I_timer_irq,
   input  logic        I_ready,
   input  logic [31:0] I_pc,
   input  logic        I_mret,
   input  logic        I_csr_we,
   input  logic [11:0] I_csr_addr,
   input  logic [31:0] I_csr_wdata,
   output logic [31:0] O_csr_rdata,
   output logic        O_interrupt,
   output logic [31:0] O_mtvec,
   output logic [31:0] O_mepc
);
   import irq_ctrl_pkg::*;

   logic        state_q, state_d;
   logic        mstatusMie_q, mstatusMie_d;
   logic        mstatusMpie_q, mstatusMpie_d;
   logic        mieMsie_q, mieMsie_d;
   logic        mieMtie_q, mieMtie_d;
   logic        mieMeie_q, mieMeie_d;
   logic        mipMsip_q, mipMsip_d;
   logic [31:2] mtvec_q, mtvec_d;
   logic [31:2] mepc_q, mepc_d;
   mcause_t     mcause_q, mcause_d;

   logic        meip;
   logic        pendMei, pendMsi, pendMti;
   logic        take, mretFire;
   logic [31:0] mipValue;
   logic        unusedPc;

   irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .I_clk (I_clk),
      .I_rst (I_rst),
      .I_d   (I_ext_irq),
      .O_q   (meip)
   );

   assign unusedPc = ^I_pc[1:0];

   assign mipValue = {20'b0, meip, 3'b0, I_timer_irq, 3'b0, mipMsip_q, 3'b0};
   assign pendMei  = meip & mieMeie_q;
   assign pendMsi  = mipMsip_q & mieMsie_q;
   assign pendMti  = I_timer_irq & mieMtie_q;

   // mret retiring blocks a take; the interrupt is simply re-evaluated next cycle.
   assign take     = (state_q == ST_RUN) & mstatusMie_q & (pendMei | pendMsi | pendMti)
                     & I_ready & ~I_mret;
   assign mretFire = (state_q == ST_RUN) & I_mret;

   always_comb begin
      O_csr_rdata = '0;
      case (I_csr_addr)
         CSR_MSTATUS: begin
            O_csr_rdata[MSTATUS_MIE]  = mstatusMie_q;
            O_csr_rdata[MSTATUS_MPIE] = mstatusMpie_q;
         end
         CSR_MIE: begin
            O_csr_rdata[IRQ_MSI] = mieMsie_q;
            O_csr_rdata[IRQ_MTI] = mieMtie_q;
            O_csr_rdata[IRQ_MEI] = mieMeie_q;
         end
         CSR_MIP:    O_csr_rdata = mipValue;
         CSR_MTVEC:  O_csr_rdata = {mtvec_q, 2'b00};
         CSR_MEPC:   O_csr_rdata = {mepc_q, 2'b00};
         CSR_MCAUSE: O_csr_rdata = {mcause_q.irq, 27'b0, mcause_q.code};
         default:    O_csr_rdata = '0;
      endcase
   end

   // Later assignments override earlier ones: CSR write < mret < trap entry.
   always_comb begin
      state_d       = take ? ST_TRAP : ST_RUN;
      mstatusMie_d  = mstatusMie_q;
      mstatusMpie_d = mstatusMpie_q;
      mieMsie_d     = mieMsie_q;
      mieMtie_d     = mieMtie_q;
      mieMeie_d     = mieMeie_q;
      mipMsip_d     = mipMsip_q;
      mtvec_d       = mtvec_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;

      if (I_csr_we) begin
         case (I_csr_addr)
            CSR_MSTATUS: begin
               mstatusMie_d  = I_csr_wdata[MSTATUS_MIE];
               mstatusMpie_d = I_csr_wdata[MSTATUS_MPIE];
            end
            CSR_MIE: begin
               mieMsie_d = I_csr_wdata[IRQ_MSI];
               mieMtie_d = I_csr_wdata[IRQ_MTI];
               mieMeie_d = I_csr_wdata[IRQ_MEI];
            end
            CSR_MIP:    mipMsip_d = I_csr_wdata[IRQ_MSI];
            CSR_MTVEC:  mtvec_d   = I_csr_wdata[31:2];
            CSR_MEPC:   mepc_d    = I_csr_wdata[31:2];
            CSR_MCAUSE: mcause_d  = {I_csr_wdata[31], I_csr_wdata[3:0]};
            default: ;
         endcase
      end

      if (mretFire) begin
         mstatusMie_d  = mstatusMpie_q;
         mstatusMpie_d = 1'b1;
      end

      if (take) begin
         mepc_d        = I_pc[31:2];
         mcause_d      = {1'b1, pickCause(pendMei, pendMsi)};
         mstatusMpie_d = mstatusMie_q;
         mstatusMie_d  = 1'b0;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q       <= ST_RUN;
         mstatusMie_q  <= 1'b0;
         mstatusMpie_q <= 1'b0;
         mieMsie_q     <= 1'b0;
         mieMtie_q     <= 1'b0;
         mieMeie_q     <= 1'b0;
         mipMsip_q     <= 1'b0;
         mtvec_q       <= RESET_MTVEC[31:2];
         mepc_q        <= '0;
         mcause_q      <= '0;
      end else begin
         state_q       <= state_d;
         mstatusMie_q  <= mstatusMie_d;
         mstatusMpie_q <= mstatusMpie_d;
         mieMsie_q     <= mieMsie_d;
         mieMtie_q     <= mieMtie_d;
         mieMeie_q     <= mieMeie_d;
         mipMsip_q     <= mipMsip_d;
         mtvec_q       <= mtvec_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
      end
   end

   assign O_interrupt = (state_q == ST_TRAP);
   assign O_mtvec     = {mtvec_q, 2'b00};
   assign O_mepc      = {mepc_q, 2'b00};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: CSR access tables followed by hand-written
// trap, mret, ready and reset sequences.
module tb_irq_ctrl;

   logic        I_clk = 1'b0;
   logic        I_rst;
   logic        I_ext_irq;
   logic        I_timer_irq;
   logic        I_ready;
   logic [31:0] I_pc;
   logic        I_mret;
   logic        I_csr_we;
   logic [11:0] I_csr_addr;
   logic [31:0] I_csr_wdata;
   logic [31:0] O_csr_rdata;
   logic        O_interrupt;
   logic [31:0] O_mtvec;
   logic [31:0] O_mepc;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRead;
   } csrVec_t;

   csrVec_t resetVecs[7];
   csrVec_t writeVecs[12];

   irq_ctrl #(.RESET_MTVEC(32'h00000010), .SYNC_STAGES(2)) dut (
      .I_clk       (I_clk),
      .I_rst       (I_rst),
      .I_ext_irq   (I_ext_irq),
      .I_timer_irq (I_timer_irq),
      .I_ready     (I_ready),
      .I_pc        (I_pc),
      .I_mret      (I_mret),
      .I_csr_we    (I_csr_we),
      .I_csr_addr  (I_csr_addr),
      .I_csr_wdata (I_csr_wdata),
      .O_csr_rdata (O_csr_rdata),
      .O_interrupt (O_interrupt),
      .O_mtvec     (O_mtvec),
      .O_mepc      (O_mepc)
   );

   always #5 I_clk = ~I_clk;

   // Inputs change and outputs are sampled on the falling edge only.
   task automatic tick();
      @(posedge I_clk);
      @(negedge I_clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic readCsr(input string name, input logic [11:0] addr, input logic [31:0] expected);
      I_csr_addr = addr;
      #1;
      checkOutput(name, O_csr_rdata, expected);
   endtask

   task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
      I_csr_we    = 1'b1;
      I_csr_addr  = addr;
      I_csr_wdata = data;
      tick();
      I_csr_we    = 1'b0;
   endtask

   task automatic applyStimulus(input string name, input csrVec_t v);
      I_csr_we    = v.we;
      I_csr_addr  = v.addr;
      I_csr_wdata = v.wdata;
      tick();
      I_csr_we    = 1'b0;
      #1;
      checkOutput(name, O_csr_rdata, v.expRead);
   endtask

   task automatic waitPulse(input string name, input int maxCycles);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < maxCycles && !seen; c++) begin
         tick();
         if (O_interrupt) seen = 1'b1;
      end
      checkOutput(name, {31'b0, seen}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset holds everything; the mtvec write under reset must be ignored.
      resetVecs[0] = '{1'b1, 12'h305, 32'hFFFF_FFFC, 32'h0000_0010};
      resetVecs[1] = '{1'b0, 12'h300, 32'h0,         32'h0000_0000};
      resetVecs[2] = '{1'b0, 12'h304, 32'h0,         32'h0000_0000};
      resetVecs[3] = '{1'b0, 12'h344, 32'h0,         32'h0000_0000};
      resetVecs[4] = '{1'b0, 12'h305, 32'h0,         32'h0000_0010};
      resetVecs[5] = '{1'b0, 12'h341, 32'h0,         32'h0000_0000};
      resetVecs[6] = '{1'b0, 12'h342, 32'h0,         32'h0000_0000};

      writeVecs[0]  = '{1'b1, 12'h305, 32'h0000_1237, 32'h0000_1234};
      writeVecs[1]  = '{1'b1, 12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
      writeVecs[2]  = '{1'b1, 12'h342, 32'hFFFF_FFFF, 32'h8000_000F};
      writeVecs[3]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
      writeVecs[4]  = '{1'b1, 12'h304, 32'hFFFF_FFFF, 32'h0000_0888};
      writeVecs[5]  = '{1'b1, 12'h344, 32'hFFFF_FFFF, 32'h0000_0008};
      writeVecs[6]  = '{1'b1, 12'h123, 32'hFFFF_FFFF, 32'h0000_0000};
      writeVecs[7]  = '{1'b1, 12'h300, 32'h0000_0000, 32'h0000_0000};
      writeVecs[8]  = '{1'b1, 12'h344, 32'h0000_0000, 32'h0000_0000};
      writeVecs[9]  = '{1'b1, 12'h304, 32'h0000_0000, 32'h0000_0000};
      writeVecs[10] = '{1'b1, 12'h342, 32'h0000_0000, 32'h0000_0000};
      writeVecs[11] = '{1'b1, 12'h341, 32'h0000_0000, 32'h0000_0000};

      I_rst       = 1'b1;
      I_ext_irq   = 1'b1;
      I_timer_irq = 1'b0;
      I_ready     = 1'b0;
      I_pc        = 32'h0;
      I_mret      = 1'b0;
      I_csr_we    = 1'b0;
      I_csr_addr  = 12'h0;
      I_csr_wdata = 32'h0;

      // Reset values, read while reset is still asserted with the external line high
      tick();
      tick();
      for (int i = 0; i < 7; i++) applyStimulus($sformatf("reset_vec%0d", i), resetVecs[i]);
      checkOutput("reset_interrupt", {31'b0, O_interrupt}, 32'd0);
      checkOutput("reset_O_mtvec", O_mtvec, 32'h0000_0010);

      I_rst     = 1'b0;
      I_ext_irq = 1'b0;
      tick();
      tick();
      tick();
      for (int i = 0; i < 12; i++) applyStimulus($sformatf("csr_vec%0d", i), writeVecs[i]);
      checkOutput("mtvec_out", O_mtvec, 32'h0000_1234);
      checkOutput("no_pulse_ready_low", {31'b0, O_interrupt}, 32'd0);

      // External interrupt: pulse exactly three cycles after the raise
      csrWrite(12'h304, 32'h0000_0800);
      csrWrite(12'h300, 32'h0000_0008);
      I_pc      = 32'h0000_0040;
      I_ready   = 1'b1;
      I_ext_irq = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checkOutput($sformatf("mei_pulse_cycle%0d", k), {31'b0, O_interrupt}, {31'b0, (k == 3)});
      end
      readCsr("mei_mepc", 12'h341, 32'h0000_0040);
      readCsr("mei_mcause", 12'h342, 32'h8000_000B);
      readCsr("mei_mstatus", 12'h300, 32'h0000_0080);
      checkOutput("mei_O_mepc", O_mepc, 32'h0000_0040);

      // All three sources pending: MEI wins, then MSI once MEI is gone
      I_timer_irq = 1'b1;
      csrWrite(12'h344, 32'h0000_0008);
      csrWrite(12'h304, 32'h0000_0888);
      csrWrite(12'h300, 32'h0000_0088);
      waitPulse("prio_mei_pulse", 4);
      readCsr("prio_mei_mcause", 12'h342, 32'h8000_000B);
      I_ready   = 1'b0;
      I_ext_irq = 1'b0;
      tick();
      tick();
      tick();
      readCsr("mip_msi_mti", 12'h344, 32'h0000_0088);
      I_mret = 1'b1;
      tick();
      I_mret = 1'b0;
      readCsr("mret_mstatus", 12'h300, 32'h0000_0088);
      I_ready = 1'b1;
      waitPulse("prio_msi_pulse", 4);
      readCsr("prio_msi_mcause", 12'h342, 32'h8000_0003);

      // mret and pending MTI in the same cycle: mret wins, trap one cycle later
      I_ready = 1'b0;
      csrWrite(12'h344, 32'h0000_0000);
      csrWrite(12'h300, 32'h0000_0088);
      I_ready = 1'b1;
      I_mret  = 1'b1;
      tick();
      I_mret  = 1'b0;
      checkOutput("mret_blocks_pulse", {31'b0, O_interrupt}, 32'd0);
      readCsr("mret_same_mstatus", 12'h300, 32'h0000_0088);
      tick();
      checkOutput("mti_after_mret_pulse", {31'b0, O_interrupt}, 32'd1);
      readCsr("mti_mcause", 12'h342, 32'h8000_0007);

      // Not ready for five cycles, then the pulse one cycle after ready
      I_ready = 1'b0;
      csrWrite(12'h300, 32'h0000_0008);
      I_pc = 32'h0000_0080;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput($sformatf("not_ready_cycle%0d", k), {31'b0, O_interrupt}, 32'd0);
      end
      I_ready = 1'b1;
      tick();
      checkOutput("ready_pulse", {31'b0, O_interrupt}, 32'd1);
      readCsr("ready_mepc", 12'h341, 32'h0000_0080);
      tick();
      checkOutput("ready_pulse_one_cycle", {31'b0, O_interrupt}, 32'd0);
      readCsr("mtvec_read", 12'h305, 32'h0000_1234);
      checkOutput("mtvec_out_again", O_mtvec, 32'h0000_1234);

      // Reset during the TRAP cycle clears the pulse and all trap state
      I_ready = 1'b0;
      csrWrite(12'h300, 32'h0000_0008);
      I_pc    = 32'h0000_0200;
      I_ready = 1'b1;
      tick();
      checkOutput("trap_before_reset", {31'b0, O_interrupt}, 32'd1);
      I_rst = 1'b1;
      tick();
      checkOutput("reset_in_trap_pulse", {31'b0, O_interrupt}, 32'd0);
      readCsr("reset_in_trap_mepc", 12'h341, 32'h0);
      readCsr("reset_in_trap_mcause", 12'h342, 32'h0);
      readCsr("reset_in_trap_mstatus", 12'h300, 32'h0);
      readCsr("reset_in_trap_mtvec", 12'h305, 32'h0000_0010);
      I_rst       = 1'b0;
      I_timer_irq = 1'b0;
      I_ready     = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
